tracking_ctrl: RTL
==================

# tracking_ctrl

Frame sequencer for the green-object tracker in the clock_50 domain. Aligns the incoming pixel stream to frame boundaries, feeds whole frames (optionally decimated) into the tracker's input FIFO, and collects the tracker's per-frame bounding-box result. Detects missing results and lost targets, and presents the latest box to downstream consumers (overlay, servo driver) over a valid/ready handshake. Owns the tracker's reset so it can resynchronise the tracker after a framing error.

## Interface
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- DECIM, 1, track one frame out of every DECIM; range 1..15.
- RES_TIMEOUT, 1024, clock_50 cycles allowed for a result after the last pixel of a frame; range 1..65535.
- LOST_FRAMES, 4, consecutive missed frames before the target is declared lost; range 1..15.

Ports:
- clock_50  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  run when 1; sampled only in IDLE.
- pix_valid  in  1  upstream pixel present.
- pix_sof  in  1  qualifies the pixel as the first pixel of a frame.
- pix_data  in  24  RGB pixel.
- pix_ready  out  1  pixel accepted this cycle.
- trk_wr_en  out  1  tracker FIFO write.
- trk_din  out  24  tracker FIFO data; equals pix_data.
- trk_full  in  1  tracker FIFO full.
- trk_rst_n  out  1  tracker reset, active-low.
- res_valid  in  1  tracker result strobe.
- res_cx, res_cy, res_w, res_h  in  12 each  tracker result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_cx, out_cy, out_w, out_h  out  12 each  published box.
- out_lost  out  1  target lost; box fields are 0.
- sync_err  out  1  one-cycle pulse on a framing error.

## Operation
- States: IDLE, SYNC, PASS, WAIT_RES, SKIP, RESYNC.
- IDLE: pix_ready=1, all pixels dropped. When enable=1, go to SYNC.
- SYNC: drop pixels (pix_ready=1) until a beat with pix_valid & pix_sof arrives. That beat is not consumed; the next cycle enters PASS, with the same beat still presented.
- PASS: pix_ready = ~trk_full; trk_wr_en = pix_valid & ~trk_full.
  - Accepted beats increment a 19-bit pixel counter.
  - The beat at count 0 carries sof. Any other accepted sof beat is a framing error: go to RESYNC.
  - When the beat at count WIDTH*HEIGHT-1 is accepted, clear the counter and go to WAIT_RES.
- WAIT_RES: drop pixels. Count cycles up to RES_TIMEOUT.
  - res_valid before timeout: hit. Clear the miss counter, publish the result, clear out_lost.
  - Timeout: miss. Increment the saturating 4-bit miss counter. Reaching LOST_FRAMES publishes a box of 0 with out_lost=1, once per loss episode.
  - Either outcome: go to SKIP if DECIM>1, else SYNC.
- SKIP: drop pixels and count sof beats. After DECIM-1 sof beats, go to SYNC. The DECIM-th sof then starts PASS.
- RESYNC: drive trk_rst_n=0 for 4 cycles, pulse sync_err on entry, drop pixels, then go to SYNC.
- res_valid outside WAIT_RES is ignored.
- Publish: load the out_* registers and set out_valid. out_valid clears on out_valid & out_ready. A publish while out_valid=1 overwrites the registers (latest wins) and keeps out_valid=1.
- enable=0 in any state other than IDLE: finish the current state, then enter IDLE instead of SYNC. The tracker is never cut mid-frame except via RESYNC.

## Timing
- Reset values: pix_ready=0, trk_wr_en=0, trk_rst_n=0, out_valid=0, out_*=0, out_lost=0, sync_err=0; state IDLE; all counters 0.
- trk_rst_n deasserts on the first clock after reset release.
- pix_ready and trk_wr_en are combinational from state, pix_valid and trk_full. trk_din is combinational from pix_data.
- Publish latency: out_valid is 1 on the cycle after res_valid, or on the cycle after the timeout count reaches RES_TIMEOUT.
- Simultaneous res_valid and timeout on the same cycle: treated as a hit.
- Simultaneous publish and out_ready on the same cycle: the new data is loaded and out_valid stays 1.
- trk_full held high stalls PASS indefinitely with no pixel loss; upstream backpressure applies.

## Configuration
- TRACK_CTRL_SMOOTH_EN defined: on a hit that is not the first hit after reset or after a loss, out_cx = (prev_cx + res_cx) >> 1 and out_cy likewise. The sum is computed with 13-bit width. out_w and out_h are not smoothed.
- TRACK_CTRL_SMOOTH_EN undefined: raw result passes through. No smoothing registers are compiled.

## Test plan
- WIDTH=4, HEIGHT=2, DECIM=1; 3 non-sof beats, then a frame with sof → first 3 beats dropped; exactly 8 trk_wr_en; res_valid with cx=2, cy=1 → out_valid next cycle with out_cx=2, out_cy=1.
- trk_full=1 for 10 cycles mid-frame → pix_ready=0 for those 10 cycles; still exactly 8 writes per frame.
- Sof at pixel 5 of 8 → sync_err pulse, trk_rst_n low for 4 cycles, tracking restarts at the next sof.
- LOST_FRAMES=2, RES_TIMEOUT=16, no res_valid for 2 frames → miss on frame 1 with no publish; publish on frame 2 with out_lost=1 and box 0; next hit clears out_lost.
- DECIM=3 over 6 frames → only frames 1 and 4 written (16 writes total).
- out_ready=0 while two hits arrive → out_* hold the second result; a single handshake clears out_valid. With TRACK_CTRL_SMOOTH_EN, hits cx=100 then cx=200 → out_cx=150.

Source files
------------

// File: rtl/tracking_ctrl.sv
// tracking_ctrl: frame sequencer for the green-object tracker (clock_50 domain).
//
// Aligns the pixel stream to frame boundaries and feeds whole frames into the
// tracker FIFO, optionally keeping only one frame in every DECIM. After each
// frame it collects the tracker's bounding-box result, counts missed frames and
// publishes the latest box, or a lost-target marker, over a valid/ready
// handshake. On a framing error it holds the tracker in reset and re-aligns.
//
// Optional feature macro: TRACK_CTRL_SMOOTH_EN. When defined, the box centre is
// averaged with the previously published centre on every hit except the first
// hit after reset or after a loss.
//
// Ports:
//   clock_50, reset        clock; asynchronous active-low reset
//   enable                 run request, acted on from IDLE
//   pix_valid/sof/data     upstream pixel stream; pix_ready = beat taken
//   trk_wr_en/trk_din      tracker FIFO write; trk_full = FIFO full
//   trk_rst_n              tracker reset, active-low
//   res_valid, res_*       tracker result strobe and box
//   out_valid/out_ready    published box handshake
//   out_cx/cy/w/h          published box; out_lost = target lost (box is 0)
//   sync_err               one-cycle pulse on a framing error
module tracking_ctrl #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned DECIM       = 1,
  parameter int unsigned RES_TIMEOUT = 1024,
  parameter int unsigned LOST_FRAMES = 4
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        trk_wr_en,
  output logic [23:0] trk_din,
  input  logic        trk_full,
  output logic        trk_rst_n,
  input  logic        res_valid,
  input  logic [11:0] res_cx,
  input  logic [11:0] res_cy,
  input  logic [11:0] res_w,
  input  logic [11:0] res_h,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_cx,
  output logic [11:0] out_cy,
  output logic [11:0] out_w,
  output logic [11:0] out_h,
  output logic        out_lost,
  output logic        sync_err
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSync    = 3'd1;
  localparam logic [2:0] StPass    = 3'd2;
  localparam logic [2:0] StWaitRes = 3'd3;
  localparam logic [2:0] StSkip    = 3'd4;
  localparam logic [2:0] StResync  = 3'd5;

  localparam logic [18:0] LastPix  = 19'(WIDTH * HEIGHT - 1);
  localparam logic [15:0] LastTmo  = 16'(RES_TIMEOUT - 1);
  localparam logic [3:0]  SkipLast = 4'((DECIM > 1) ? (DECIM - 2) : 0);
  localparam logic [3:0]  LostLvl  = 4'(LOST_FRAMES);
  localparam bit          UseSkip  = (DECIM > 1);

  logic [2:0]  state_q, state_d;
  logic        alive_q;
  logic [18:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic [3:0]  skip_cnt_q, skip_cnt_d;
  logic [1:0]  rsy_cnt_q, rsy_cnt_d;
  logic        trk_rst_q, trk_rst_d;
  logic        sync_err_q, sync_err_d;
  logic        out_valid_q, out_valid_d;
  logic [11:0] out_cx_q, out_cx_d;
  logic [11:0] out_cy_q, out_cy_d;
  logic [11:0] out_w_q, out_w_d;
  logic [11:0] out_h_q, out_h_d;
  logic        out_lost_q, out_lost_d;

  logic        hit, miss, pub_lost;
  logic [3:0]  miss_inc;
  logic [2:0]  home_st;

`ifdef TRACK_CTRL_SMOOTH_EN
  logic        have_prev_q, have_prev_d;
  logic [12:0] sum_cx, sum_cy;
`endif

  // Pixel side. alive_q keeps pix_ready low until the first clock after reset.
  always_comb begin
    pix_ready = 1'b0;
    if (alive_q) begin
      case (state_q)
        StPass:  pix_ready = ~trk_full;
        // The aligning sof beat is held so PASS can consume it next cycle.
        StSync:  pix_ready = ~(pix_valid & pix_sof);
        default: pix_ready = 1'b1;
      endcase
    end
  end

  assign trk_wr_en = (state_q == StPass) & pix_valid & ~trk_full;
  assign trk_din   = pix_data;

  // Where a finished state goes: SYNC normally, IDLE once enable has dropped.
  assign home_st  = enable ? StSync : StIdle;
  assign miss_inc = (miss_cnt_q == 4'hF) ? miss_cnt_q : miss_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    skip_cnt_d = skip_cnt_q;
    rsy_cnt_d  = rsy_cnt_q;
    trk_rst_d  = 1'b1;
    sync_err_d = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StSync;
      end
      StSync: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (pix_valid && pix_sof) begin
          state_d   = StPass;
          pix_cnt_d = '0;
        end
      end
      StPass: begin
        if (pix_valid && !trk_full) begin
          if (pix_sof && (pix_cnt_q != '0)) begin
            state_d    = StResync;
            pix_cnt_d  = '0;
            rsy_cnt_d  = '0;
            trk_rst_d  = 1'b0;
            sync_err_d = 1'b1;
          end else if (pix_cnt_q == LastPix) begin
            state_d   = StWaitRes;
            pix_cnt_d = '0;
            tmo_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 19'd1;
          end
        end
      end
      StWaitRes: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        // A result on the timeout cycle still counts as a hit.
        if (res_valid) begin
          hit = 1'b1;
        end else if (tmo_cnt_q == LastTmo) begin
          miss = 1'b1;
        end
        if (hit || miss) begin
          tmo_cnt_d  = '0;
          skip_cnt_d = '0;
          state_d    = UseSkip ? StSkip : home_st;
        end
      end
      StSkip: begin
        if (pix_valid && pix_sof) begin
          if (skip_cnt_q == SkipLast) begin
            skip_cnt_d = '0;
            state_d    = home_st;
          end else begin
            skip_cnt_d = skip_cnt_q + 4'd1;
          end
        end
      end
      StResync: begin
        // Tracker stays in reset for all four RESYNC cycles.
        if (rsy_cnt_q == 2'd3) begin
          state_d = home_st;
        end else begin
          rsy_cnt_d = rsy_cnt_q + 2'd1;
          trk_rst_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Miss tracking and the published box.
  always_comb begin
    miss_cnt_d  = miss_cnt_q;
    pub_lost    = 1'b0;
    out_valid_d = out_valid_q & ~out_ready;
    out_cx_d    = out_cx_q;
    out_cy_d    = out_cy_q;
    out_w_d     = out_w_q;
    out_h_d     = out_h_q;
    out_lost_d  = out_lost_q;
`ifdef TRACK_CTRL_SMOOTH_EN
    have_prev_d = have_prev_q;
    sum_cx      = {1'b0, out_cx_q} + {1'b0, res_cx};
    sum_cy      = {1'b0, out_cy_q} + {1'b0, res_cy};
`endif
    if (miss) begin
      miss_cnt_d = miss_inc;
      // out_lost_q marks an episode already reported.
      pub_lost   = (miss_inc >= LostLvl) && !out_lost_q;
    end
    if (hit) begin
      miss_cnt_d  = '0;
      out_valid_d = 1'b1;
      out_cx_d    = res_cx;
      out_cy_d    = res_cy;
      out_w_d     = res_w;
      out_h_d     = res_h;
      out_lost_d  = 1'b0;
`ifdef TRACK_CTRL_SMOOTH_EN
      // out_cx_q/out_cy_q hold the previous published centre.
      if (have_prev_q) begin
        out_cx_d = sum_cx[12:1];
        out_cy_d = sum_cy[12:1];
      end
      have_prev_d = 1'b1;
`endif
    end
    if (pub_lost) begin
      out_valid_d = 1'b1;
      out_cx_d    = '0;
      out_cy_d    = '0;
      out_w_d     = '0;
      out_h_d     = '0;
      out_lost_d  = 1'b1;
`ifdef TRACK_CTRL_SMOOTH_EN
      have_prev_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      alive_q     <= 1'b0;
      pix_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      skip_cnt_q  <= '0;
      rsy_cnt_q   <= '0;
      trk_rst_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_cx_q    <= '0;
      out_cy_q    <= '0;
      out_w_q     <= '0;
      out_h_q     <= '0;
      out_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= 1'b1;
      pix_cnt_q   <= pix_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      rsy_cnt_q   <= rsy_cnt_d;
      trk_rst_q   <= trk_rst_d;
      sync_err_q  <= sync_err_d;
      out_valid_q <= out_valid_d;
      out_cx_q    <= out_cx_d;
      out_cy_q    <= out_cy_d;
      out_w_q     <= out_w_d;
      out_h_q     <= out_h_d;
      out_lost_q  <= out_lost_d;
    end
  end

`ifdef TRACK_CTRL_SMOOTH_EN
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) have_prev_q <= 1'b0;
    else        have_prev_q <= have_prev_d;
  end
`endif

  assign trk_rst_n = trk_rst_q;
  assign sync_err  = sync_err_q;
  assign out_valid = out_valid_q;
  assign out_cx    = out_cx_q;
  assign out_cy    = out_cy_q;
  assign out_w     = out_w_q;
  assign out_h     = out_h_q;
  assign out_lost  = out_lost_q;

endmodule
